// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte producers.
// Captures a byte, hands it over with valid/ready, waits for frame done, then enforces a gap.
module uart_tx_arbiter #(
   parameter int N          = 4,
   parameter int GAP_CYCLES = 16,
   parameter int TIMEOUT    = 200000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [8*N-1:0]       req_data,
   output logic [N-1:0]         req_ack,
   input  logic                 parity_en,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_parity,
   input  logic                 tx_ready,
   input  logic                 tx_done,
   output logic                 busy,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 timeout_err
);

   localparam int PW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PW:0] N_W = (PW+1)'(N);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_e;

   state_e         state_q, state_d;
   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]  grant_id_q, grant_id_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_parity_q, tx_parity_d;
   logic [N-1:0]   req_ack_q, req_ack_d;
   logic           timeout_err_q, timeout_err_d;

   logic           sel_found;
   logic [PW-1:0]  sel_idx;
   logic [PW:0]    cand;
   logic [PW-1:0]  next_ptr;

   // First pending requester scanning upward from rr_ptr, wrapping at N (not at 2**PW).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (cand >= N_W) cand = cand - N_W;
         if (!sel_found && req[cand[PW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[PW-1:0];
         end
      end
      next_ptr = (sel_idx == PW'(N-1)) ? '0 : sel_idx + 1'b1;
   end

   // NOTE: synchronous reset clears every flop, so outputs are all zero on the reset edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         timer_q       <= '0;
         gap_cnt_q     <= '0;
         tx_data_q     <= '0;
         tx_parity_q   <= 1'b0;
         req_ack_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         timer_q       <= timer_d;
         gap_cnt_q     <= gap_cnt_d;
         tx_data_q     <= tx_data_d;
         tx_parity_q   <= tx_parity_d;
         req_ack_q     <= req_ack_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // NOTE: every variable gets a hold/default value first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      timer_d       = timer_q;
      gap_cnt_d     = gap_cnt_q;
      tx_data_d     = tx_data_q;
      tx_parity_d   = tx_parity_q;
      req_ack_d     = '0;
      timeout_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               req_ack_d[sel_idx] = 1'b1;
               tx_data_d          = req_data[{sel_idx, 3'b000} +: 8];
               tx_parity_d        = parity_en;
               grant_id_d         = sel_idx;
               rr_ptr_d           = next_ptr;
               timer_d            = '0;
               state_d            = S_SEND;
            end
         end
         S_SEND, S_WAIT: begin
            timer_d = timer_q + 1'b1;
            // A frame-done pulse beats a watchdog expiry landing on the same edge.
            if (state_q == S_WAIT && tx_done) begin
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end else if (timer_d == TW'(TIMEOUT-1)) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else if (state_q == S_SEND && tx_ready) begin
               state_d = S_WAIT;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GW'(GAP_CYCLES-1)) state_d = S_IDLE;
            else                                gap_cnt_d = gap_cnt_q + 1'b1;
         end
      endcase
   end

   always_comb begin
      tx_valid = (state_q == S_SEND);
      busy     = (state_q != S_IDLE);
   end

   assign req_ack     = req_ack_q;
   assign tx_data     = tx_data_q;
   assign tx_parity   = tx_parity_q;
   assign grant_id    = grant_id_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter among N byte-producing requesters. It captures one byte from the granted requester and presents it to the transmitter with a valid/ready handshake. It then waits for the transmitter's frame-done pulse and enforces an inter-frame gap before serving the next requester. It sits between client logic and the transmitter/baud-generator datapath, and includes a watchdog so that a stalled transmitter cannot hang the arbiter.

Parameters:
N, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle clk cycles between end of one frame and next capture (0 allowed)
TIMEOUT, 200000, max clk cycles from capture to tx_done before abort (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  N  per-requester request level; bit i high = byte pending on req_data slice i
req_data  input  8*N  byte for requester i at [8*i+7:8*i]
req_ack  output  N  one-hot, one-cycle pulse: requester i's byte captured this cycle
parity_en  input  1  parity mode, latched at capture
tx_valid  output  1  byte on tx_data valid for transmitter
tx_data  output  8  captured byte
tx_parity  output  1  latched parity_en for current frame
tx_ready  input  1  transmitter can accept; transfer occurs on tx_valid & tx_ready
tx_done  input  1  one-cycle pulse (clk domain): frame fully shifted out
busy  output  1  high in any state other than IDLE
grant_id  output  clog2(N)  index of requester owning current frame
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (synchronous, sampled on clk edge) takes effect on the same edge, including mid-frame:
  - state=IDLE, rr_ptr=0, timer=0.
  - All outputs 0: req_ack, tx_valid, tx_data, tx_parity, busy, grant_id, timeout_err.
  - No req_ack is issued on the reset edge.
- States: IDLE, SEND, WAIT, GAP.
- IDLE:
  - If req!=0, select the first set bit scanning from rr_ptr upward, wrapping modulo N.
  - On that edge: req_ack[i]=1 for one cycle; tx_data<=req_data slice i; tx_parity<=parity_en; grant_id<=i; rr_ptr<=(i+1) mod N; timer<=0; state->SEND.
  - Capture latency is 1 cycle from req seen high to req_ack.
  - The requester may change req_data or drop req after ack; the captured byte is unaffected.
  - A requester holding req high after ack is re-arbitrated normally and is not served twice in a row while others wait.
- SEND:
  - tx_valid=1; tx_data and tx_parity stable.
  - On an edge with tx_ready=1: transfer done; tx_valid=0 next cycle; state->WAIT.
  - tx_done seen while in SEND is ignored.
- WAIT:
  - tx_valid=0.
  - On tx_done=1: state->GAP if GAP_CYCLES>0, else ->IDLE.
- Watchdog:
  - timer increments every cycle in SEND and WAIT.
  - If timer reaches TIMEOUT-1 without leaving WAIT via tx_done: timeout_err pulses 1 cycle, tx_valid=0, state->IDLE, no gap.
  - tx_done on the same edge as timeout takes priority; no error is raised.
- GAP:
  - Counter counts GAP_CYCLES cycles, then state->IDLE.
  - req is ignored during GAP.
  - Next capture occurs no earlier than GAP_CYCLES+1 cycles after the tx_done edge.
- busy=0 only in IDLE; busy rises on the capture edge.
- rr_ptr is updated only on capture; timeout does not alter it.
- Widths:
  - rr_ptr and grant_id are clog2(N) bits; wrap from N-1 to 0 (including non-power-of-2 N).
  - timer is clog2(TIMEOUT) bits and never wraps.

Test Plan:
- Single request: reset, then req=4'b0001, data0=8'hA5, parity_en=1, tx_ready=1. Required: req_ack=0001 one cycle later; tx_valid for 1 cycle with tx_data=A5, tx_parity=1; tx_done after 20 cycles -> busy stays high 16 more cycles (GAP) then 0.
- Fairness: req=4'b1111 held, data i = 8'h10+i, tx_done 5 cycles after each accept. Required grant order 0,1,2,3,0 with tx_data 10,11,12,13,10; each req_ack one-hot.
- Backpressure: req=4'b0100, tx_ready low 7 cycles then high. Required: tx_valid high 8 cycles with tx_data constant; req_ack only once; WAIT entered after the ready edge.
- Timeout: TIMEOUT=50, accept byte, never pulse tx_done. Required: timeout_err pulse exactly 49 cycles after capture; busy=0 next cycle; next pending req captured without gap.
- Reset mid-frame: assert reset during WAIT with req=4'b0010 held. Required: all outputs 0 on reset edge; after release, requester 1 captured first (rr_ptr=0 scan) 1 cycle after reset deasserts.
- GAP_CYCLES=0 with req=4'b0011: required capture of requester 1 one cycle after tx_done of requester 0's frame.
